// File: rtl/biriscv_icache_arb.sv
// ---------------------------------------------------------------------------
// biriscv_icache_arb
//
// Shares the single instruction-cache request port between the fetch unit
// (requester F) and an auxiliary instruction-side reader (requester A).
// One 64-bit aligned read is outstanding at a time. The owner of that read
// is remembered so the response can be routed back to it. Fetch has
// priority.
//
// Optional feature (macro BIRISCV_ICACHE_ARB_STARVE_EN):
//   When defined, a saturating 4-bit counter measures how long A has been
//   refused. Once it reaches STARVE_LIMIT, A is boosted ahead of F for one
//   grant. When undefined, strict F priority applies and A may starve.
//
// Parameters:
//   STARVE_LIMIT       refused-A cycles before the boost is set (1..15)
//
// Ports:
//   clk_i, rst_i                 clock, async active-high reset
//   f_rd_i/f_pc_i/f_priv_i       fetch request
//   f_flush_i                    fetch flush, passed to icache_flush_o
//   f_accept_o, f_valid_o        fetch accept / response valid
//   a_rd_i/a_pc_i/a_priv_i       aux request
//   a_accept_o, a_valid_o        aux accept / response valid
//   rsp_inst_o/error/page_fault  shared response payload
//   icache_rd_o/pc/priv/flush    request to the icache
//   icache_accept_i              icache took the request
//   icache_valid_i/inst/error/page_fault  icache response
// ---------------------------------------------------------------------------
module biriscv_icache_arb #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        f_rd_i,
  input  logic [31:0] f_pc_i,
  input  logic [1:0]  f_priv_i,
  input  logic        f_flush_i,
  output logic        f_accept_o,
  output logic        f_valid_o,

  input  logic        a_rd_i,
  input  logic [31:0] a_pc_i,
  input  logic [1:0]  a_priv_i,
  output logic        a_accept_o,
  output logic        a_valid_o,

  output logic [63:0] rsp_inst_o,
  output logic        rsp_error_o,
  output logic        rsp_page_fault_o,

  output logic        icache_rd_o,
  output logic [31:0] icache_pc_o,
  output logic [1:0]  icache_priv_o,
  output logic        icache_flush_o,
  input  logic        icache_accept_i,
  input  logic        icache_valid_i,
  input  logic [63:0] icache_inst_i,
  input  logic        icache_error_i,
  input  logic        icache_page_fault_i
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t state_q, state_d;
  logic   owner_q, owner_d;   // 0 = F, 1 = A
  logic   boost_q;

  logic   free;
  logic   gnt_f;
  logic   gnt_a;
  logic   rsp_vld;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    owner_d          = owner_q;
    icache_rd_o      = 1'b0;
    icache_pc_o      = 32'h0;
    icache_priv_o    = 2'b00;
    f_accept_o       = 1'b0;
    a_accept_o       = 1'b0;
    f_valid_o        = 1'b0;
    a_valid_o        = 1'b0;
    rsp_inst_o       = 64'h0;
    rsp_error_o      = 1'b0;
    rsp_page_fault_o = 1'b0;

    // A returning response frees the port in the same cycle, allowing
    // back-to-back issue.
    free  = (state_q == IDLE) || icache_valid_i;

    // A wins when boosted, or when F is not asking at all.
    gnt_a = free && a_rd_i && (boost_q || !f_rd_i);
    gnt_f = free && f_rd_i && !gnt_a;

    // Responses only count while something is outstanding; a response in
    // IDLE (e.g. one that straddled a reset) is dropped.
    rsp_vld = (state_q == WAIT) && icache_valid_i;

    if (gnt_f) begin
      icache_rd_o   = 1'b1;
      icache_pc_o   = f_pc_i & 32'hFFFF_FFF8;
      icache_priv_o = f_priv_i;
    end else if (gnt_a) begin
      icache_rd_o   = 1'b1;
      icache_pc_o   = a_pc_i & 32'hFFFF_FFF8;
      icache_priv_o = a_priv_i;
    end

    f_accept_o = gnt_f && icache_accept_i;
    a_accept_o = gnt_a && icache_accept_i;

    if (rsp_vld) begin
      f_valid_o        = !owner_q;
      a_valid_o        = owner_q;
      rsp_inst_o       = icache_inst_i;
      rsp_error_o      = icache_error_i;
      rsp_page_fault_o = icache_page_fault_i;
      state_d          = IDLE;
    end

    // A newly accepted request overrides the return to IDLE.
    if (f_accept_o || a_accept_o) begin
      state_d = WAIT;
      owner_d = a_accept_o;
    end
  end

  assign icache_flush_o = f_flush_i;

`ifdef BIRISCV_ICACHE_ARB_STARVE_EN
  logic [3:0] starve_q;
  logic [3:0] starve_d;

  always_comb begin
    starve_d = starve_q;
    if (!a_rd_i || a_accept_o)
      starve_d = 4'd0;
    else if (starve_q != 4'hF)
      starve_d = starve_q + 4'd1;
  end

  // The boost is sticky until A actually gets accepted, so it survives
  // cycles where the port is busy or A briefly drops its request.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      starve_q <= 4'd0;
      boost_q  <= 1'b0;
    end else begin
      starve_q <= starve_d;
      if (a_accept_o)
        boost_q <= 1'b0;
      else if (starve_d == 4'(STARVE_LIMIT))
        boost_q <= 1'b1;
    end
  end
`else
  assign boost_q = 1'b0;
`endif

endmodule

// File: tb/tb_biriscv_icache_arb.sv
module tb_biriscv_icache_arb;

  logic        clk;
  logic        rst;
  logic        f_rd, f_flush, a_rd;
  logic [31:0] f_pc, a_pc;
  logic [1:0]  f_priv, a_priv;
  logic        f_accept, f_valid, a_accept, a_valid;
  logic [63:0] rsp_inst;
  logic        rsp_error, rsp_pf;
  logic        ic_rd, ic_flush, ic_accept, ic_valid, ic_error, ic_pf;
  logic [31:0] ic_pc;
  logic [1:0]  ic_priv;
  logic [63:0] ic_inst;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        is_a;
    logic [63:0] inst;
    logic        err;
    logic        pf;
  } rsp_t;

  rsp_t sb[$];

  biriscv_icache_arb #(.STARVE_LIMIT(3)) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .f_rd_i              (f_rd),
    .f_pc_i              (f_pc),
    .f_priv_i            (f_priv),
    .f_flush_i           (f_flush),
    .f_accept_o          (f_accept),
    .f_valid_o           (f_valid),
    .a_rd_i              (a_rd),
    .a_pc_i              (a_pc),
    .a_priv_i            (a_priv),
    .a_accept_o          (a_accept),
    .a_valid_o           (a_valid),
    .rsp_inst_o          (rsp_inst),
    .rsp_error_o         (rsp_error),
    .rsp_page_fault_o    (rsp_pf),
    .icache_rd_o         (ic_rd),
    .icache_pc_o         (ic_pc),
    .icache_priv_o       (ic_priv),
    .icache_flush_o      (ic_flush),
    .icache_accept_i     (ic_accept),
    .icache_valid_i      (ic_valid),
    .icache_inst_i       (ic_inst),
    .icache_error_i      (ic_error),
    .icache_page_fault_i (ic_pf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every response the DUT presents must match the
  // oldest expected response.
  always @(negedge clk) begin
    rsp_t e;
    if (f_valid || a_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: f_valid=%0b a_valid=%0b, expected no response", f_valid, a_valid);
      end else begin
        e = sb.pop_front();
        chk("rsp_f_valid", {63'b0, f_valid}, {63'b0, !e.is_a});
        chk("rsp_a_valid", {63'b0, a_valid}, {63'b0, e.is_a});
        chk("rsp_inst", rsp_inst, e.inst);
        chk("rsp_error", {63'b0, rsp_error}, {63'b0, e.err});
        chk("rsp_page_fault", {63'b0, rsp_pf}, {63'b0, e.pf});
      end
    end
  end

  task automatic clr();
    f_rd = 0; f_pc = 0; f_priv = 0; f_flush = 0;
    a_rd = 0; a_pc = 0; a_priv = 0;
    ic_accept = 0; ic_valid = 0; ic_inst = 0; ic_error = 0; ic_pf = 0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic expect_rsp(input logic is_a, input logic [63:0] inst, input logic err, input logic pf);
    rsp_t e;
    e.is_a = is_a; e.inst = inst; e.err = err; e.pf = pf;
    sb.push_back(e);
  endtask

  logic prev_a;
  logic exp_a;
  int   a_cnt;

  initial begin
    clr();
    rst = 1;
    next(); next();
    smp();
    chk("reset_icache_rd", {63'b0, ic_rd}, 64'd0);
    chk("reset_icache_pc", {32'b0, ic_pc}, 64'd0);
    chk("reset_accepts", {62'b0, f_accept, a_accept}, 64'd0);
    chk("reset_valids", {62'b0, f_valid, a_valid}, 64'd0);
    chk("reset_rsp_inst", rsp_inst, 64'd0);
    chk("reset_flush_priv", {61'b0, ic_flush, ic_priv}, 64'd0);
    next();
    rst = 0;

    // Single F read, aligned address, response two cycles later
    f_rd = 1; f_pc = 32'h8000_0004; f_priv = 2'd3; ic_accept = 1;
    smp();
    chk("f1_icache_rd", {63'b0, ic_rd}, 64'd1);
    chk("f1_icache_pc", {32'b0, ic_pc}, 64'h8000_0000);
    chk("f1_icache_priv", {62'b0, ic_priv}, 64'd3);
    chk("f1_f_accept", {63'b0, f_accept}, 64'd1);
    chk("f1_a_accept", {63'b0, a_accept}, 64'd0);
    next(); clr();
    smp();
    chk("f1_wait_no_rd", {63'b0, ic_rd}, 64'd0);
    next();
    ic_valid = 1; ic_inst = 64'h1234;
    expect_rsp(1'b0, 64'h1234, 1'b0, 1'b0);
    smp();
    chk("f1_f_valid", {63'b0, f_valid}, 64'd1);
    chk("f1_a_valid", {63'b0, a_valid}, 64'd0);
    next(); clr();

    // Unaccepted grant leaves state IDLE; following response is spurious
    f_rd = 1; f_pc = 32'h40; ic_accept = 0;
    smp();
    chk("noacc_icache_rd", {63'b0, ic_rd}, 64'd1);
    chk("noacc_f_accept", {63'b0, f_accept}, 64'd0);
    next(); clr();
    ic_valid = 1; ic_inst = 64'hDEAD;
    smp();
    chk("spurious_valids", {62'b0, f_valid, a_valid}, 64'd0);
    next(); clr();

    // Back-to-back issue in the response cycle
    f_rd = 1; f_pc = 32'h48; ic_accept = 1;
    smp();
    chk("b2b_first_accept", {63'b0, f_accept}, 64'd1);
    next();
    f_rd = 1; f_pc = 32'h50; ic_accept = 1; ic_valid = 1; ic_inst = 64'hAAAA;
    expect_rsp(1'b0, 64'hAAAA, 1'b0, 1'b0);
    smp();
    chk("b2b_f_accept", {63'b0, f_accept}, 64'd1);
    chk("b2b_f_valid", {63'b0, f_valid}, 64'd1);
    chk("b2b_icache_pc", {32'b0, ic_pc}, 64'h50);
    next(); clr();
    f_rd = 1; f_pc = 32'h58; ic_accept = 1;
    smp();
    chk("b2b_still_wait_rd", {63'b0, ic_rd}, 64'd0);
    chk("b2b_still_wait_acc", {63'b0, f_accept}, 64'd0);
    next(); clr();
    ic_valid = 1; ic_inst = 64'hBBBB; ic_error = 1;
    expect_rsp(1'b0, 64'hBBBB, 1'b1, 1'b0);
    smp();
    next(); clr();

    // A request outstanding across a fetch flush
    a_rd = 1; a_pc = 32'h2004; a_priv = 2'd1; ic_accept = 1;
    smp();
    chk("aux_a_accept", {63'b0, a_accept}, 64'd1);
    chk("aux_f_accept", {63'b0, f_accept}, 64'd0);
    chk("aux_icache_pc", {32'b0, ic_pc}, 64'h2000);
    chk("aux_icache_priv", {62'b0, ic_priv}, 64'd1);
    next(); clr();
    f_flush = 1;
    smp();
    chk("flush_pass", {63'b0, ic_flush}, 64'd1);
    chk("flush_no_valid", {62'b0, f_valid, a_valid}, 64'd0);
    next(); clr();
    ic_valid = 1; ic_inst = 64'hCAFE; ic_pf = 1;
    expect_rsp(1'b1, 64'hCAFE, 1'b0, 1'b1);
    smp();
    chk("flush_a_valid", {63'b0, a_valid}, 64'd1);
    chk("flush_f_valid", {63'b0, f_valid}, 64'd0);
    next(); clr();

    // Reset while a request is outstanding
    f_rd = 1; f_pc = 32'h300; ic_accept = 1;
    smp();
    chk("rstw_f_accept", {63'b0, f_accept}, 64'd1);
    next(); clr();
    rst = 1;
    smp();
    chk("rstw_icache_rd", {63'b0, ic_rd}, 64'd0);
    next();
    rst = 0;
    ic_valid = 1; ic_inst = 64'h1;
    smp();
    chk("rstw_late_valids", {62'b0, f_valid, a_valid}, 64'd0);
    next(); clr();
    f_rd = 1; f_pc = 32'h308; ic_accept = 1;
    smp();
    chk("rstw_regrant_rd", {63'b0, ic_rd}, 64'd1);
    chk("rstw_regrant_acc", {63'b0, f_accept}, 64'd1);
    next(); clr();
    ic_valid = 1; ic_inst = 64'h77;
    expect_rsp(1'b0, 64'h77, 1'b0, 1'b0);
    smp();
    next(); clr();

    // F and A contend continuously; icache answers the cycle after accept
    prev_a = 0;
    a_cnt = 0;
    for (int k = 0; k < 50; k++) begin
      f_rd = 1; f_pc = 32'h1000 + 32'(k * 8);
      a_rd = 1; a_pc = 32'h9000;
      ic_accept = 1;
      ic_valid = (k > 0);
      ic_inst = 64'(k);
      if (k > 0) expect_rsp(prev_a, 64'(k), 1'b0, 1'b0);
`ifdef BIRISCV_ICACHE_ARB_STARVE_EN
      exp_a = ((k % 4) == 3);
`else
      exp_a = 1'b0;
`endif
      smp();
      chk($sformatf("contend_a_accept_%0d", k), {63'b0, a_accept}, {63'b0, exp_a});
      chk($sformatf("contend_f_accept_%0d", k), {63'b0, f_accept}, {63'b0, !exp_a});
      if (a_accept) a_cnt++;
      prev_a = exp_a;
      next();
    end
    clr();
    ic_valid = 1; ic_inst = 64'd50;
    expect_rsp(prev_a, 64'd50, 1'b0, 1'b0);
    smp();
    next(); clr();
`ifdef BIRISCV_ICACHE_ARB_STARVE_EN
    chk("contend_a_total", 64'(a_cnt), 64'd12);
`else
    chk("contend_a_total", 64'(a_cnt), 64'd0);
`endif

    next();
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
